// File: rtl/fetch_pkg.sv
// Shared state encoding and default geometry for the fetch sequencer.
// The FETCH_PERF_EN macro enables the optional stall counter in fetch_sequencer.
package fetch_pkg;

    localparam int         FETCH_AW       = 8;
    localparam int         FETCH_DW       = 8;
    localparam logic [7:0] FETCH_RESET_PC = 8'h00;
    localparam int         FETCH_PERF_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // States in which a memory request is outstanding on the bus.
    function automatic logic is_mem_state(input fetch_state_e s);
        return (s == REQ) || (s == DROP);
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter used for fetch stall accounting.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one memory request at a time,
// holds the fetched word for decode and applies branch redirects. Optional FETCH_PERF_EN adds stall_cnt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int            AW       = FETCH_AW,
    parameter int            DW       = FETCH_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC)
`ifdef FETCH_PERF_EN
    ,
    parameter int            PERF_W   = FETCH_PERF_W
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [DW-1:0]     imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DW-1:0]     instr_code,
    output logic [AW-1:0]     instr_pc,
    input  logic              redir_valid,
    input  logic [AW-1:0]     redir_offset
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    fetch_state_e  state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] br_pc_q;
    logic [AW-1:0] drop_addr_q;
    logic          instr_valid_q;
    logic [DW-1:0] instr_code_q;
    logic [AW-1:0] instr_pc_q;

    logic [AW-1:0] target_d;
    logic [AW-1:0] pc_inc_d;

    // Branch target is relative to the last instruction handed to decode.
    assign target_d = br_pc_q + redir_offset;
    assign pc_inc_d = pc_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            br_pc_q       <= RESET_PC;
            drop_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_code_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redir_valid) begin
                        pc_q <= target_d;
                    end
                    state_q <= REQ;
                end
                REQ: begin
                    if (redir_valid) begin
                        pc_q <= target_d;
                        // An unanswered request must still complete; park its address and drain it.
                        if (!imem_ack) begin
                            drop_addr_q <= pc_q;
                            state_q     <= DROP;
                        end
                    end else if (imem_ack) begin
                        instr_code_q  <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        pc_q          <= pc_inc_d;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (redir_valid) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= target_d;
                        state_q       <= REQ;
                    end else if (instr_ready) begin
                        br_pc_q       <= instr_pc_q;
                        instr_valid_q <= 1'b0;
                        state_q       <= REQ;
                    end
                end
                DROP: begin
                    if (redir_valid) begin
                        pc_q <= target_d;
                    end
                    if (imem_ack) begin
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = is_mem_state(state_q);
    assign imem_addr   = (state_q == DROP) ? drop_addr_q : pc_q;
    assign instr_valid = instr_valid_q;
    assign instr_code  = instr_code_q;
    assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_EN
    logic stall_d;

    assign stall_d = (is_mem_state(state_q) && !imem_ack) ||
                     ((state_q == HOLD) && !instr_ready);

    fetch_perf_counter #(
        .W       (PERF_W)
    ) u_perf (
        .Clk     (Clk),
        .Reset   (Reset),
        .inc_i   (stall_d),
        .count_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of expected transfer PCs,
// a latency-programmable memory responder and one task per scenario.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int AW = FETCH_AW;
    localparam int DW = FETCH_DW;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_code;
    logic [AW-1:0] instr_pc;
    logic          redir_valid = 1'b0;
    logic [AW-1:0] redir_offset = '0;
`ifdef FETCH_PERF_EN
    logic [FETCH_PERF_W-1:0] stall_cnt;
`endif

    fetch_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_code   (instr_code),
        .instr_pc     (instr_pc),
        .redir_valid  (redir_valid),
        .redir_offset (redir_offset)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int            checks = 0;
    int            failures = 0;
    int            mon_cycle = 0;
    int            lat = 1;
    int            wait_cnt = 0;
    logic          force_ack = 1'b0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            xfer_q[$];

    // Memory contents as seen by the responder.
    function automatic logic [DW-1:0] code_of(input logic [AW-1:0] a);
        return a * 8'd3 + 8'h5A;
    endfunction

    // Memory responder: acks 'lat' cycles after a request appears.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 8'hEE;
                wait_cnt   = 0;
            end else if (Reset || !imem_req) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = code_of(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic monitor();
        logic [AW-1:0] e;
        if (!Reset) begin
            if (imem_req && imem_ack) addr_q.push_back(imem_addr);
            if (instr_valid && instr_ready && !redir_valid) begin
                xfer_q.push_back(mon_cycle);
                $display("xfer pc=%02h code=%02h cycle=%0d", instr_pc, instr_code, mon_cycle);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_xfer: got pc=%02h, required no transfer", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e) begin
                        failures++;
                        $display("FAIL xfer_pc: got %02h, required %02h", instr_pc, e);
                    end
                    checks++;
                    if (instr_code !== code_of(e)) begin
                        failures++;
                        $display("FAIL xfer_code: got %02h, required %02h", instr_code, code_of(e));
                    end
                end
            end
        end
    endtask

    task automatic to_neg();
        @(negedge Clk);
        mon_cycle++;
        monitor();
    endtask

    task automatic to_pos();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        to_neg();
        to_pos();
    endtask

    task automatic apply_reset(input int n);
        Reset = 1'b1;
        redir_valid = 1'b0;
        force_ack = 1'b0;
        repeat (n) tick();
        exp_q.delete();
        addr_q.delete();
        xfer_q.delete();
        Reset = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending transfers, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_addr(input int idx, input logic [AW-1:0] want, input string name);
        checks++;
        if (addr_q.size() <= idx) begin
            failures++;
            $display("FAIL %s: got only %0d acked requests, required entry %0d = %02h", name, addr_q.size(), idx, want);
        end else if (addr_q[idx] !== want) begin
            failures++;
            $display("FAIL %s: got addr %02h, required %02h", name, addr_q[idx], want);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        lat = 1;
        instr_ready = 1'b1;
        to_pos();
        tick();
        to_neg();
        checks += 4;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b, required 0", imem_req); end
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
        if (instr_code !== '0) begin failures++; $display("FAIL rst_code: got %02h, required 00", instr_code); end
        if (instr_pc !== '0) begin failures++; $display("FAIL rst_pc: got %02h, required 00", instr_pc); end
`ifdef FETCH_PERF_EN
        checks++;
        if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall: got %0d, required 0", stall_cnt); end
`endif
        to_pos();
        Reset = 1'b0;
        to_neg();
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b, required 0", imem_req); end
        to_pos();
        to_neg();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== FETCH_RESET_PC) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%02h, required req=1 addr=%02h", imem_req, imem_addr, FETCH_RESET_PC);
        end
        to_pos();
    endtask

    task automatic test_sequential();
        lat = 1;
        instr_ready = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
        wait_drain(60, "seq");
        for (int i = 0; i < 6; i++) check_addr(i, AW'(i), "seq_addr");
        checks++;
        if (xfer_q.size() < 6) begin
            failures++;
            $display("FAIL seq_rate: got %0d transfers, required 6", xfer_q.size());
        end else if (xfer_q[5] - xfer_q[0] != 15) begin
            failures++;
            $display("FAIL seq_rate: got %0d cycles for 5 intervals, required 15", xfer_q[5] - xfer_q[0]);
        end
    endtask

    task automatic test_latency_stall();
        int n;
        logic [AW-1:0] a0;
        logic [DW-1:0] code0;
        lat = 3;
        instr_ready = 1'b0;
        apply_reset(2);
        exp_q.push_back(FETCH_RESET_PC);
        n = 0;
        to_neg();
        while (!imem_req && n < 10) begin to_pos(); to_neg(); n++; end
        a0 = imem_addr;
        checks++;
        if (imem_req !== 1'b1 || a0 !== FETCH_RESET_PC) begin
            failures++;
            $display("FAIL lat_req: got req=%b addr=%02h, required req=1 addr=%02h", imem_req, a0, FETCH_RESET_PC);
        end
        for (int k = 0; k < 8; k++) begin
            to_pos();
            to_neg();
            if (imem_ack) break;
            checks++;
            if (imem_addr !== a0) begin failures++; $display("FAIL lat_addr_stable: got %02h, required %02h", imem_addr, a0); end
        end
        n = 0;
        while (!instr_valid && n < 10) begin to_pos(); to_neg(); n++; end
        code0 = instr_code;
        checks++;
        if (instr_valid !== 1'b1 || code0 !== code_of(FETCH_RESET_PC)) begin
            failures++;
            $display("FAIL lat_hold: got valid=%b code=%02h, required valid=1 code=%02h", instr_valid, code0, code_of(FETCH_RESET_PC));
        end
        for (int k = 0; k < 4; k++) begin
            to_pos();
            to_neg();
            checks++;
            if (instr_valid !== 1'b1 || instr_code !== code0) begin
                failures++;
                $display("FAIL hold_stable: got valid=%b code=%02h, required valid=1 code=%02h", instr_valid, instr_code, code0);
            end
        end
        to_pos();
        instr_ready = 1'b1;
        wait_drain(20, "lat");
    endtask

    task automatic test_redirect_drop();
        lat = 1;
        instr_ready = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
        wait_drain(60, "drop_pre");
        lat = 3;
        redir_valid = 1'b1;
        redir_offset = 8'h10;
        exp_q.push_back(8'h15);
        tick();
        redir_valid = 1'b0;
        to_neg();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h06 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_state: got req=%b addr=%02h valid=%b, required req=1 addr=06 valid=0", imem_req, imem_addr, instr_valid);
        end
        to_pos();
        wait_drain(30, "drop");
        check_addr(6, 8'h06, "drop_old_addr");
        check_addr(7, 8'h15, "drop_target_addr");
    endtask

    task automatic test_redirect_hold();
        int n;
        lat = 1;
        instr_ready = 1'b1;
        apply_reset(2);
        exp_q.push_back(8'h00);
        wait_drain(20, "hold_pre");
        instr_ready = 1'b0;
        n = 0;
        to_neg();
        while (!instr_valid && n < 10) begin to_pos(); to_neg(); n++; end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h01) begin
            failures++;
            $display("FAIL hold_pre_pc: got valid=%b pc=%02h, required valid=1 pc=01", instr_valid, instr_pc);
        end
        to_pos();
        instr_ready = 1'b1;
        redir_valid = 1'b1;
        redir_offset = 8'h30;
        exp_q.push_back(8'h30);
        tick();
        redir_valid = 1'b0;
        to_neg();
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL hold_discard: got valid=%b, required 0", instr_valid); end
        to_pos();
        wait_drain(20, "hold");
    endtask

    task automatic test_pc_wrap();
        lat = 1;
        instr_ready = 1'b1;
        apply_reset(2);
        redir_valid = 1'b1;
        redir_offset = 8'hF8;
        tick();
        redir_valid = 1'b0;
        exp_q.push_back(8'hF8);
        wait_drain(20, "wrap_f8");
        redir_valid = 1'b1;
        redir_offset = 8'h10;
        exp_q.push_back(8'h08);
        tick();
        redir_valid = 1'b0;
        wait_drain(20, "wrap_br");
        check_addr(1, 8'hF9, "wrap_drop_addr");
        check_addr(2, 8'h08, "wrap_br_target");

        apply_reset(2);
        redir_valid = 1'b1;
        redir_offset = 8'hFF;
        tick();
        redir_valid = 1'b0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        wait_drain(30, "wrap_ff");
        check_addr(0, 8'hFF, "wrap_ff_addr");
        check_addr(1, 8'h00, "wrap_next_addr");
    endtask

    task automatic test_reset_drop();
        lat = 50;
        instr_ready = 1'b1;
        apply_reset(2);
        tick();
        redir_valid = 1'b1;
        redir_offset = 8'h40;
        tick();
        redir_valid = 1'b0;
        to_neg();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL rdrop_state: got req=%b addr=%02h, required req=1 addr=00", imem_req, imem_addr);
        end
        to_pos();
        Reset = 1'b1;
        tick();
        to_neg();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdrop_reset: got req=%b valid=%b, required req=0 valid=0", imem_req, instr_valid);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (stall_cnt !== '0) begin failures++; $display("FAIL rdrop_stall: got %0d, required 0", stall_cnt); end
`endif
        to_pos();
        Reset = 1'b0;
        force_ack = 1'b1;
        lat = 1;
        exp_q.delete();
        addr_q.delete();
        exp_q.push_back(FETCH_RESET_PC);
        tick();
        force_ack = 1'b0;
        to_neg();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== FETCH_RESET_PC || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rdrop_restart: got req=%b addr=%02h valid=%b, required req=1 addr=%02h valid=0",
                     imem_req, imem_addr, instr_valid, FETCH_RESET_PC);
        end
        to_pos();
        wait_drain(20, "rdrop");
        check_addr(0, FETCH_RESET_PC, "rdrop_first_addr");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_latency_stall();
        test_redirect_drop();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
